// File: rtl/mem_copy_engine.sv
// Single-command bus master for the 2048x8 multi-bank memory: block copy or block fill,
// with a one-cycle done pulse and an XOR checksum of every byte written.
//
// Handshake: a command is accepted on a clock edge where start=1 and the engine is in IDLE.
// start is ignored in every other state, so the caller needs no ready signal.
// Completion is a one-cycle done pulse.
module mem_copy_engine #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] pattern,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              ren,
    output logic              wen,
    output logic [ADDR_W-1:0] raddr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state, state_n;
    logic              mode_r, mode_n;
    logic [ADDR_W-1:0] src_r, src_n;
    logic [ADDR_W-1:0] dst_r, dst_n;
    logic [ADDR_W-1:0] len_r, len_n;
    logic [DATA_W-1:0] pat_r, pat_n;
    logic [ADDR_W-1:0] cnt, cnt_n, cnt_inc;
    logic [DATA_W-1:0] data_r, data_n;
    logic [DATA_W-1:0] csum_n;
    logic              busy_n, done_n, ren_n, wen_n;
    logic [ADDR_W-1:0] raddr_n, waddr_n;
    logic [DATA_W-1:0] din_n;

    assign cnt_inc   = cnt + ADDR_W'(1);
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        mode_n  = mode_r;
        src_n   = src_r;
        dst_n   = dst_r;
        len_n   = len_r;
        pat_n   = pat_r;
        cnt_n   = cnt;
        data_n  = data_r;
        csum_n  = checksum;

        case (state)
            IDLE: begin
                if (start) begin
                    mode_n = mode;
                    src_n  = src_addr;
                    dst_n  = dst_addr;
                    len_n  = len;
                    pat_n  = pattern;
                    cnt_n  = '0;
                    data_n = '0;
                    csum_n = '0;
                    if (len == '0)
                        state_n = DONE;
                    else if (mode)
                        state_n = WR;
                    else
                        state_n = RD;
                end
            end
            RD: state_n = RDW;
            RDW: begin
                data_n  = dout;
                state_n = WR;
            end
            WR: begin
                csum_n = checksum ^ din;
                cnt_n  = cnt_inc;
                if (cnt_inc == len_r)
                    state_n = DONE;
                else if (mode_r)
                    state_n = WR;
                else
                    state_n = RD;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered (Moore).
        busy_n  = (state_n == RD) || (state_n == RDW) || (state_n == WR);
        done_n  = (state_n == DONE);
        ren_n   = (state_n == RD) || (state_n == RDW);
        wen_n   = (state_n == WR);
        raddr_n = ren_n ? (src_n + cnt_n) : '0;
        waddr_n = wen_n ? (dst_n + cnt_n) : '0;
        din_n   = wen_n ? (mode_n ? pat_n : data_n) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mode_r   <= 1'b0;
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            pat_r    <= '0;
            cnt      <= '0;
            data_r   <= '0;
            checksum <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ren      <= 1'b0;
            wen      <= 1'b0;
            raddr    <= '0;
            waddr    <= '0;
            din      <= '0;
        end else begin
            state    <= state_n;
            mode_r   <= mode_n;
            src_r    <= src_n;
            dst_r    <= dst_n;
            len_r    <= len_n;
            pat_r    <= pat_n;
            cnt      <= cnt_n;
            data_r   <= data_n;
            checksum <= csum_n;
            busy     <= busy_n;
            done     <= done_n;
            ren      <= ren_n;
            wen      <= wen_n;
            raddr    <= raddr_n;
            waddr    <= waddr_n;
            din      <= din_n;
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a local 2048x8 memory model, directed commands,
// and expected reads/writes/done events compared by an independent monitor.
module tb_mem_copy_engine;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int MEM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] pattern = '0;
    logic          busy, done, ren, wen;
    logic [DW-1:0] checksum, din;
    logic [DW-1:0] dout = '0;
    logic [AW-1:0] raddr, waddr;
    logic [2:0]    state_dbg;

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
        .busy(busy), .done(done), .checksum(checksum),
        .ren(ren), .wen(wen), .raddr(raddr), .waddr(waddr), .din(din), .dout(dout),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / memory model ----------------
    always #5 clk = ~clk;

    logic [DW-1:0] mem [MEM_N];
    logic [DW-1:0] ref_mem [MEM_N];
    logic          pre_we = 1'b0;
    logic          pre_clr = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_clr) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (wen && !ren) begin
            mem[waddr] <= din;
        end
        dout <= ren ? mem[raddr] : '0;
    end

    // ---------------- scoreboard ----------------
    logic [32+AW-1:0]    rd_exp_q [$];   // {cycle, raddr}
    logic [32+AW+DW-1:0] wr_exp_q [$];   // {cycle, waddr, din}
    logic [64+DW-1:0]    done_exp_q [$]; // {busy cycles, cycle, checksum}
    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    logic [32+AW-1:0]    e_rd;
    logic [32+AW+DW-1:0] e_wr;
    logic [64+DW-1:0]    e_dn;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            checks++;
            if (ren && wen) begin
                errors++;
                $display("FAIL ren_wen_overlap cyc=%0d ren=%b wen=%b required not both", cyc, ren, wen);
            end
            checks++;
            if (!busy && (ren || wen || raddr != '0 || waddr != '0 || din != '0)) begin
                errors++;
                $display("FAIL idle_bus cyc=%0d ren=%b wen=%b raddr=%h waddr=%h din=%h required all 0",
                         cyc, ren, wen, raddr, waddr, din);
            end
            if (ren) begin
                checks++;
                if (rd_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read cyc=%0d raddr=%h required no read", cyc, raddr);
                end else begin
                    e_rd = rd_exp_q.pop_front();
                    if (raddr != e_rd[AW-1:0] || cyc != int'(e_rd[32+AW-1:AW])) begin
                        errors++;
                        $display("FAIL read cyc=%0d raddr=%h required cyc=%0d raddr=%h",
                                 cyc, raddr, e_rd[32+AW-1:AW], e_rd[AW-1:0]);
                    end
                end
            end
            if (wen) begin
                checks++;
                if (wr_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write cyc=%0d waddr=%h din=%h required no write", cyc, waddr, din);
                end else begin
                    e_wr = wr_exp_q.pop_front();
                    if (waddr != e_wr[AW+DW-1:DW] || din != e_wr[DW-1:0] ||
                        cyc != int'(e_wr[32+AW+DW-1:AW+DW])) begin
                        errors++;
                        $display("FAIL write cyc=%0d waddr=%h din=%h required cyc=%0d waddr=%h din=%h",
                                 cyc, waddr, din, e_wr[32+AW+DW-1:AW+DW], e_wr[AW+DW-1:DW], e_wr[DW-1:0]);
                    end
                end
            end
            if (done) begin
                checks++;
                if (done_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d required no done", cyc);
                end else begin
                    e_dn = done_exp_q.pop_front();
                    if (cyc != int'(e_dn[32+DW-1:DW]) || checksum != e_dn[DW-1:0] ||
                        busy_cnt != int'(e_dn[64+DW-1:32+DW])) begin
                        errors++;
                        $display("FAIL done cyc=%0d checksum=%h busy_cycles=%0d required cyc=%0d checksum=%h busy_cycles=%0d",
                                 cyc, checksum, busy_cnt, e_dn[32+DW-1:DW], e_dn[DW-1:0], e_dn[64+DW-1:32+DW]);
                    end
                end
                busy_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_checksum"}, 32'(checksum), 0);
        chk({tag, "_ren"}, 32'(ren), 0);
        chk({tag, "_wen"}, 32'(wen), 0);
        chk({tag, "_raddr"}, 32'(raddr), 0);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_din"}, 32'(din), 0);
    endtask

    // abort_at != 0: reset is pulsed in that cycle; events later than it are not expected.
    task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int n, input logic [DW-1:0] p, input int repulse, input int abort_at);
        int c, w, lim, budget;
        logic [DW-1:0] v, cs;
        logic [AW-1:0] sa, da;
        @(negedge clk);
        c = cyc;
        cs = '0;
        lim = (abort_at == 0) ? 32'h3fff_ffff : abort_at;
        for (int k = 0; k < n; k++) begin
            sa = s + AW'(k);
            da = d + AW'(k);
            if (!m) begin
                v = ref_mem[sa];
                if (3*k+1 <= lim) rd_exp_q.push_back({32'(c+3*k+1), sa});
                if (3*k+2 <= lim) rd_exp_q.push_back({32'(c+3*k+2), sa});
                w = 3*k + 3;
            end else begin
                v = p;
                w = k + 1;
            end
            if (w <= lim) wr_exp_q.push_back({32'(c+w), da, v});
            if (w < lim) begin
                ref_mem[da] = v;
                cs ^= v;
            end
        end
        if (abort_at == 0)
            done_exp_q.push_back({32'(m ? n : 3*n), 32'(c + (m ? n : 3*n) + 1), cs});
        mode = m;
        src_addr = s;
        dst_addr = d;
        len = AW'(n);
        pattern = p;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        mode = 1'($urandom_range(0, 1));
        src_addr = AW'($urandom_range(0, MEM_N-1));
        dst_addr = AW'($urandom_range(0, MEM_N-1));
        len = AW'($urandom_range(0, MEM_N-1));
        pattern = DW'($urandom_range(0, 255));
        if (abort_at != 0) begin
            while (cyc != c + abort_at) @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_outputs_zero("abort");
            repeat (2) @(negedge clk);
            #2;
            rst_n = 1'b1;
        end else begin
            budget = 3*n + 10;
            for (int i = 0; i < budget && done_exp_q.size() != 0; i++) begin
                @(negedge clk);
                #1;
                start = (repulse != 0) && (cyc == c + repulse);
            end
            start = 1'b0;
            if (done_exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL done_timeout cyc=%0d pending=%0d required 0", cyc, done_exp_q.size());
                done_exp_q.delete();
                rd_exp_q.delete();
                wr_exp_q.delete();
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < MEM_N; i++) ref_mem[i] = '0;
        pre_clr = 1'b1;
        repeat (2) @(negedge clk);
        pre_clr = 1'b0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        run_cmd(1'b1, 11'h000, 11'h010, 4, 8'hA5, 0, 0);        // fill
        preload(11'h100, 8'h11);
        preload(11'h101, 8'h22);
        preload(11'h102, 8'h33);
        run_cmd(1'b0, 11'h100, 11'h700, 3, 8'h00, 0, 0);        // copy across banks
        run_cmd(1'b1, 11'h000, 11'h7FE, 4, 8'h5A, 0, 0);        // fill with wrap
        run_cmd(1'b0, 11'h123, 11'h456, 0, 8'hFF, 0, 0);        // len 0
        for (int i = 0; i < 5; i++) preload(11'h040 + 11'(i), 8'h01 << i);
        run_cmd(1'b0, 11'h040, 11'h050, 5, 8'h00, 6, 0);        // start re-pulsed mid-copy
        for (int i = 0; i < 4; i++) preload(11'h600 + 11'(i), 8'hC0 + 8'(i));
        run_cmd(1'b0, 11'h600, 11'h601, 4, 8'h00, 0, 0);        // overlapping copy propagates
        run_cmd(1'b0, 11'h7FF, 11'h3FE, 3, 8'h00, 0, 0);        // copy with source wrap
        preload(11'h200, 8'h9C);
        preload(11'h201, 8'h47);
        preload(11'h202, 8'hE1);
        run_cmd(1'b0, 11'h200, 11'h300, 3, 8'h00, 0, 4);        // reset in cycle 4
        run_cmd(1'b0, 11'h200, 11'h310, 3, 8'h00, 0, 0);        // normal after reset
        run_cmd(1'b1, 11'h000, 11'h020, 1, 8'h81, 0, 0);        // single-byte fill

        repeat (3) @(negedge clk);
        #1;
        chk("rd_queue_left", 32'(rd_exp_q.size()), 0);
        chk("wr_queue_left", 32'(wr_exp_q.size()), 0);
        chk("done_queue_left", 32'(done_exp_q.size()), 0);
        for (int i = 0; i < MEM_N; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL readback addr=%h actual=%h required=%h", i[AW-1:0], mem[i], ref_mem[i]);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-master sequencer that drives the 2048×8 multi-bank memory's request interface (ren, wen, waddr, raddr, din, dout). It executes one command at a time, either a block copy (read src, write dst) or a block fill (write a constant pattern), and reports completion with a one-cycle done pulse and an XOR checksum of the bytes written. It sits between the lab's control logic and the multi-bank memory and is the memory's only initiator.

## Interface
- ADDR_W, 11, memory address width (2048 bytes)
- DATA_W, 8, data width
- clk  in  1  system clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = copy, 1 = fill; sampled with start
- src_addr  in  ADDR_W  copy source base
- dst_addr  in  ADDR_W  destination base (copy and fill)
- len  in  ADDR_W  byte count, 0..2047
- pattern  in  DATA_W  fill value; sampled with start
- busy  out  1  high from the cycle after an accepted start through the last memory access
- done  out  1  one-cycle pulse on command completion
- checksum  out  DATA_W  XOR of all bytes written by the last command; stable while not busy
- ren  out  1  memory read enable
- wen  out  1  memory write enable
- raddr  out  ADDR_W  memory read address
- waddr  out  ADDR_W  memory write address
- din  out  DATA_W  memory write data
- dout  in  DATA_W  memory read data

## Operation
- Memory contract: read data appears on dout one cycle after the edge that samples ren/raddr, and only while ren and raddr are still held. ren has priority over wen inside the memory, so ren and wen are never asserted together.
- All outputs are registered (Moore). Outside RD/RDW/WR: ren=wen=0, raddr=waddr=0, din=0.
- States: IDLE, RD, RDW, WR, DONE.
- IDLE: on start=1, latch mode, src, dst, len and pattern, clear checksum to 0, and clear byte counter cnt to 0.
  - len==0 goes to DONE.
  - Otherwise copy goes to RD and fill goes to WR.
- RD: ren=1, raddr=src+cnt. Goes to RDW.
- RDW: ren=1, raddr held. At the end of the cycle, capture dout into data_r. Goes to WR.
- WR: wen=1, waddr=dst+cnt, din=data_r for copy or pattern for fill. On leaving WR: checksum ^= din and cnt++. If cnt+1==len go to DONE, else go to RD (copy) or WR (fill).
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W: src+cnt and dst+cnt wrap 2047→0 with no error.
- Copies run in ascending order with no overlap protection. If dst lies within (src, src+len), the copy propagates already-written bytes; this is the defined behaviour.
- start is ignored in RD/RDW/WR/DONE. Command inputs may change freely once the start is accepted.
- rst_n low at any time, including mid-command: immediately go to IDLE and clear all outputs, checksum and counters. Unwritten bytes are abandoned and no done pulse is issued.

## Timing
- E0 is the edge that accepts start.
- Copy of N≥1 bytes:
  - Byte k occupies RD in cycle 3k+1, RDW in 3k+2, WR in 3k+3 (cycles numbered after E0).
  - busy is high for 3N cycles; done is high in cycle 3N+1.
- Fill of N≥1 bytes: WR in cycles 1..N, busy for N cycles, done in cycle N+1.
- len==0: done in cycle 1, busy never asserted, no memory traffic.
- A new start is accepted at the earliest in the cycle after DONE (IDLE). Back-to-back commands therefore have one IDLE cycle between them.
- Reset values: busy=0, done=0, checksum=0, ren=0, wen=0, raddr=0, waddr=0, din=0.

## Test plan
- Fill, dst=0x010, len=4, pattern=0xA5 → wen high for exactly 4 cycles at waddrs 0x010..0x013, din=0xA5, done in cycle 5, checksum=0x00; read-back gives 0xA5 ×4.
- Copy, preload 0x100..0x102={0x11,0x22,0x33}, src=0x100, dst=0x700, len=3 → read/write pairs cross bank boundaries, done in cycle 10, checksum=0x00 (0x11^0x22^0x33), 0x700..0x702 match the source; ren and wen are never high together.
- Wrap: fill dst=0x7FE, len=4, pattern=0x5A → writes at 0x7FE, 0x7FF, 0x000, 0x001.
- len=0 with mode=0 → done pulse in cycle 1, busy stays 0, ren=wen=0 throughout.
- start re-pulsed mid-copy (len=5) → ignored; exactly 15 busy cycles and one done.
- rst_n pulsed low in cycle 4 of a len=3 copy → all outputs 0 asynchronously, no done, only byte 0 written; a subsequent command runs normally.
